// File: rtl/tip_memory_unit.sv
// tip_memory_unit: word-addressed memory unit with a local RAM, status flags,
// indirect pointer channels, an IRQ register and a timed peripheral window.
// Local reads return one cycle after acceptance; peripheral accesses stall the
// requester (busy) until peri_ack arrives or the wait budget runs out.
module tip_memory_unit #(
  parameter  int DATA_W       = 16,
  parameter  int ADDR_W       = 11,
  parameter  int MEM_WORDS    = 512,
  parameter  int N_IND        = 2,
  parameter  int PERI_BASE    = 'h300,
  parameter  int PERI_SPAN    = 'h100,
  parameter  int PERI_TIMEOUT = 15,
  localparam int PW           = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  input  logic [DATA_W-1:0] wreg,
  input  logic              flag_load,
  input  logic              carry_in,
  input  logic              zero_in,
  output logic              carry_out,
  output logic              zero_out,
  output logic              peri_req,
  output logic              peri_we,
  output logic [7:0]        peri_addr,
  output logic [DATA_W-1:0] peri_wdata,
  input  logic              peri_ack,
  input  logic [DATA_W-1:0] peri_rdata,
  input  logic              peri_irq,
  output logic              interrupt
);

  localparam int CW = $clog2(PERI_TIMEOUT + 1);
  localparam logic [DATA_W-1:0] DEAD = DATA_W'(16'hDEAD);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      ack_done, to_done;

  logic [DATA_W-1:0]         ram [MEM_WORDS];
  logic [N_IND-1:0][PW-1:0]  ptr_q;
  logic [N_IND-1:0]          inc_q;
  logic                      carry_q, zero_q, irq_en_q, bus_err_q;
  logic                      rvalid_q;
  logic [DATA_W-1:0]         rdata_q;
  logic                      pwe_q;
  logic [7:0]                paddr_q;
  logic [DATA_W-1:0]         pwdata_q;

  logic [31:0]               a32;
  logic                      is_ram, is_peri, is_wreg, is_carry, is_zero, is_irq;
  logic [N_IND-1:0]          indv_oh, inda_oh;
  logic [PW-1:0]             sel_ptr, ram_addr;
  logic                      sel_inc;
  logic [DATA_W-1:0]         inda_val, rd_mux;
  logic                      accept, wr_acc;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (32'(p) == 32'(MEM_WORDS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign a32    = 32'(addr);
  assign accept = req && (state_q == S_IDLE);
  assign wr_acc = accept && we;

  // Address decode and local read-data mux.
  always_comb begin
    is_ram   = a32 < 32'(MEM_WORDS);
    is_peri  = (a32 >= 32'(PERI_BASE)) && (a32 < 32'(PERI_BASE + PERI_SPAN));
    is_wreg  = a32 == 32'h200;
    is_carry = a32 == 32'h201;
    is_zero  = a32 == 32'h202;
    is_irq   = a32 == 32'h20B;
    indv_oh  = '0;
    inda_oh  = '0;
    sel_ptr  = '0;
    sel_inc  = 1'b0;
    for (int k = 0; k < N_IND; k++) begin
      if (a32 == 32'('h203 + 2 * k)) begin
        indv_oh[k] = 1'b1;
        sel_ptr    = ptr_q[k];
        sel_inc    = inc_q[k];
      end
      if (a32 == 32'('h204 + 2 * k)) begin
        inda_oh[k] = 1'b1;
        sel_ptr    = ptr_q[k];
        sel_inc    = inc_q[k];
      end
    end
    ram_addr = is_ram ? addr[PW-1:0] : sel_ptr;
    inda_val = '0;
    inda_val[PW-1:0]   = sel_ptr;
    inda_val[DATA_W-1] = sel_inc;
    rd_mux = DEAD;
    if (is_ram || (|indv_oh)) rd_mux = ram[ram_addr];
    else if (|inda_oh)        rd_mux = inda_val;
    else if (is_wreg)         rd_mux = wreg;
    else if (is_carry)        rd_mux = DATA_W'(carry_q);
    else if (is_zero)         rd_mux = DATA_W'(zero_q);
    else if (is_irq)          rd_mux = DATA_W'({bus_err_q, irq_en_q, peri_irq});
  end

  // Peripheral FSM state register; reset aborts any outstanding access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Peripheral FSM next state: ack wins over timeout on the last wait cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_done = 1'b0;
    to_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && is_peri) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (peri_ack) begin
          ack_done = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == CW'(PERI_TIMEOUT - 1)) begin
          to_done = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registers, flags, pointers, read return and peripheral command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      inc_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      bus_err_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      pwe_q     <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (accept && !we && !is_peri) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end
      if (ack_done && !pwe_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= peri_rdata;
      end
      if (to_done) begin
        bus_err_q <= 1'b1;
        if (!pwe_q) begin
          rvalid_q <= 1'b1;
          rdata_q  <= DEAD;
        end
      end
      if (accept && is_peri) begin
        pwe_q    <= we;
        paddr_q  <= 8'(a32 - 32'(PERI_BASE));
        pwdata_q <= wdata;
      end
      if (wr_acc && is_carry) carry_q <= wdata[0];
      else if (flag_load)     carry_q <= carry_in;
      if (wr_acc && is_zero)  zero_q  <= wdata[0];
      else if (flag_load)     zero_q  <= zero_in;
      if (wr_acc && is_irq) begin
        irq_en_q <= wdata[1];
        if (wdata[2]) bus_err_q <= 1'b0;
      end
      for (int k = 0; k < N_IND; k++) begin
        if (wr_acc && inda_oh[k]) begin
          ptr_q[k] <= wdata[PW-1:0];
          inc_q[k] <= wdata[DATA_W-1];
        end else if (accept && indv_oh[k] && inc_q[k]) begin
          ptr_q[k] <= ptr_next(ptr_q[k]);
        end
      end
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc && (is_ram || (|indv_oh))) ram[ram_addr] <= wdata;
  end

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign busy       = (state_q == S_WAIT);
  assign peri_req   = (state_q == S_WAIT);
  assign peri_we    = pwe_q;
  assign peri_addr  = paddr_q;
  assign peri_wdata = pwdata_q;
  assign carry_out  = carry_q;
  assign zero_out   = zero_q;
  assign interrupt  = irq_en_q && (peri_irq || bus_err_q);

endmodule

// File: tb/tb_tip_memory_unit.sv
// Bench for tip_memory_unit: transaction-level model of the memory map,
// randomized accesses, and a negedge compare process.
module tb_tip_memory_unit;
  localparam int TO = 15;
  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        reset, req, we, flag_load, carry_in, zero_in;
  logic        peri_ack, peri_irq;
  logic [10:0] addr;
  logic [15:0] wdata, wreg, peri_rdata;
  logic [15:0] rdata, peri_wdata;
  logic        rvalid, busy, carry_out, zero_out, peri_req, peri_we, interrupt;
  logic [7:0]  peri_addr;

  tip_memory_unit dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .busy(busy), .wreg(wreg),
    .flag_load(flag_load), .carry_in(carry_in), .zero_in(zero_in),
    .carry_out(carry_out), .zero_out(zero_out), .peri_req(peri_req),
    .peri_we(peri_we), .peri_addr(peri_addr), .peri_wdata(peri_wdata),
    .peri_ack(peri_ack), .peri_rdata(peri_rdata), .peri_irq(peri_irq),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  logic [15:0] mem_m [512];
  logic [8:0]  ptr_m [NI];
  bit          inc_m [NI];
  bit          carry_m, zero_m, irqen_m, buserr_m;
  // expected outputs for the current cycle
  bit          exp_rv, exp_busy, exp_pwe;
  logic [15:0] exp_rd, exp_pwd;
  logic [7:0]  exp_paddr, last_paddr;
  bit          rnd_fl;
  int          nb;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // every cycle: compare DUT outputs with the model
  always @(negedge clk) begin
    chk("rvalid", 16'(rvalid), 16'(exp_rv));
    if (exp_rv) chk("rdata", rdata, exp_rd);
    chk("busy", 16'(busy), 16'(exp_busy));
    chk("peri_req", 16'(peri_req), 16'(exp_busy));
    chk("carry_out", 16'(carry_out), 16'(carry_m));
    chk("zero_out", 16'(zero_out), 16'(zero_m));
    chk("interrupt", 16'(interrupt), 16'(irqen_m && (peri_irq || buserr_m)));
    if (exp_busy) begin
      chk("peri_addr", 16'(peri_addr), 16'(exp_paddr));
      chk("peri_we", 16'(peri_we), 16'(exp_pwe));
      if (exp_pwe) chk("peri_wdata", peri_wdata, exp_pwd);
    end
  end

  function automatic logic [15:0] m_read(input logic [10:0] a);
    int ai = int'(a);
    int k;
    if (ai < 512) return mem_m[ai];
    if (ai == 'h200) return wreg;
    if (ai == 'h201) return {15'b0, carry_m};
    if (ai == 'h202) return {15'b0, zero_m};
    if (ai == 'h20B) return {13'b0, buserr_m, irqen_m, peri_irq};
    if (ai >= 'h203 && ai <= 'h20A) begin
      k = (ai - 'h203) / 2;
      if (k < NI) begin
        if ((ai - 'h203) % 2 == 0) return mem_m[ptr_m[k]];
        return {inc_m[k], 6'b0, ptr_m[k]};
      end
    end
    return 16'hDEAD;
  endfunction

  // apply the effect of one clock edge to the model
  task automatic m_commit(input bit acc, input bit w, input logic [10:0] a, input logic [15:0] d);
    int ai = int'(a);
    int k;
    bit swc = acc && w && (ai == 'h201);
    bit swz = acc && w && (ai == 'h202);
    carry_m = swc ? d[0] : (flag_load ? carry_in : carry_m);
    zero_m  = swz ? d[0] : (flag_load ? zero_in : zero_m);
    if (!acc) return;
    if (ai >= 'h203 && ai <= 'h20A) begin
      k = (ai - 'h203) / 2;
      if (k < NI) begin
        if ((ai - 'h203) % 2 == 0) begin
          if (w) mem_m[ptr_m[k]] = d;
          if (inc_m[k]) ptr_m[k] = 9'((int'(ptr_m[k]) + 1) % 512);
        end else if (w) begin
          ptr_m[k] = d[8:0];
          inc_m[k] = d[15];
        end
      end
    end
    if (w && ai < 512) mem_m[ai] = d;
    if (w && ai == 'h20B) begin
      irqen_m = d[1];
      if (d[2]) buserr_m = 1'b0;
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < NI; k++) begin ptr_m[k] = '0; inc_m[k] = 1'b0; end
    carry_m = 0; zero_m = 0; irqen_m = 0; buserr_m = 0;
    exp_rv = 0; exp_busy = 0;
  endtask

  task automatic rnd_side();
    wreg = 16'($urandom);
    if (rnd_fl) begin
      flag_load = 1'($urandom); carry_in = 1'($urandom);
      zero_in = 1'($urandom); peri_irq = 1'($urandom);
    end
  endtask

  // one local (non-peripheral) access
  task automatic op(input bit w, input logic [10:0] a, input logic [15:0] d);
    logic [15:0] v;
    rnd_side();
    peri_ack = ($urandom_range(0, 3) == 0);
    peri_rdata = 16'($urandom);
    req = 1; we = w; addr = a; wdata = d;
    v = m_read(a);
    @(posedge clk);
    m_commit(1, w, a, d);
    #1;
    req = 0; peri_ack = 0;
    exp_rv = !w; exp_rd = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      rnd_side();
      peri_ack = 1'($urandom);
      @(posedge clk);
      m_commit(0, 0, '0, '0);
      #1;
      peri_ack = 0; exp_rv = 0;
    end
  endtask

  // peripheral access; ack in wait cycle dly (0 or > TO means no ack)
  task automatic pop(input bit w, input logic [10:0] a, input logic [15:0] d,
                     input int dly, input logic [15:0] pd, output int nbusy);
    bit acked = (dly >= 1 && dly <= TO);
    rnd_side();
    peri_ack = 1'($urandom);
    req = 1; we = w; addr = a; wdata = d;
    @(posedge clk);
    m_commit(1, w, a, d);
    #1;
    req = 0; peri_ack = 0;
    exp_rv = 0; exp_busy = 1; exp_pwe = w;
    exp_paddr = 8'(int'(a) - 'h300); exp_pwd = d;
    last_paddr = peri_addr;
    nbusy = 0;
    for (int c = 1; c <= TO; c++) begin
      rnd_side();
      peri_ack = (c == dly);
      peri_rdata = (c == dly) ? pd : 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        req = 1; we = 1'($urandom); addr = 11'($urandom); wdata = 16'($urandom);
      end else req = 0;
      @(posedge clk);
      m_commit(0, 0, '0, '0);
      #1;
      req = 0;
      nbusy++;
      if (c == dly) break;
    end
    peri_ack = 0;
    exp_busy = 0;
    exp_rv = !w;
    exp_rd = acked ? pd : 16'hDEAD;
    if (!acked) buserr_m = 1;
  endtask

  task automatic reset_in_wait();
    rnd_side();
    req = 1; we = 0; addr = 11'h320; wdata = '0; peri_ack = 0;
    @(posedge clk);
    m_commit(1, 0, 11'h320, '0);
    #1;
    req = 0; exp_rv = 0; exp_busy = 1; exp_pwe = 0; exp_paddr = 8'h20;
    repeat (2) begin
      rnd_side();
      @(posedge clk);
      m_commit(0, 0, '0, '0);
      #1;
    end
    rnd_fl = 0; flag_load = 0;
    reset = 1;
    #1;
    chk("rst_wait_busy", 16'(busy), 16'h0);
    chk("rst_wait_peri_req", 16'(peri_req), 16'h0);
    m_reset();
    @(posedge clk); @(posedge clk);
    #1;
    reset = 0; rnd_fl = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] a;
    int r;
    reset = 1; req = 0; we = 0; addr = '0; wdata = '0; wreg = '0;
    flag_load = 0; carry_in = 0; zero_in = 0; peri_ack = 0; peri_rdata = '0;
    peri_irq = 0; rnd_fl = 0; last_paddr = '0; exp_rd = '0; exp_pwe = 0;
    exp_pwd = '0; exp_paddr = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rvalid", 16'(rvalid), 16'h0);
    chk("reset_busy", 16'(busy), 16'h0);
    chk("reset_carry", 16'(carry_out), 16'h0);
    reset = 0;
    rnd_fl = 1;

    for (int i = 0; i < 512; i++) op(1, 11'(i), 16'($urandom));

    // write/read round trip
    op(1, 11'd5, 16'h1234);
    op(0, 11'd5, '0);
    chk("lit_rd5_valid", 16'(rvalid), 16'h1);
    chk("lit_rd5", rdata, 16'h1234);

    // indirect channel with wrap
    op(1, 11'h000, 16'h5555);
    op(1, 11'h204, 16'h81FF);
    op(1, 11'h203, 16'hAAAA);
    op(0, 11'h203, '0);
    chk("lit_indv0_wrap", rdata, 16'h5555);
    op(0, 11'h204, '0);
    chk("lit_inda0", rdata, 16'h8001);
    op(0, 11'h1FF, '0);
    chk("lit_ram1ff", rdata, 16'hAAAA);

    // software flag write beats flag_load
    rnd_fl = 0; flag_load = 1; carry_in = 0; zero_in = 1; peri_irq = 0;
    op(1, 11'h201, 16'h0001);
    chk("lit_carry_sw", 16'(carry_out), 16'h1);
    op(1, 11'h202, 16'h0000);
    chk("lit_zero_sw", 16'(zero_out), 16'h0);
    idle(1);
    chk("lit_carry_load", 16'(carry_out), 16'h0);
    chk("lit_zero_load", 16'(zero_out), 16'h1);
    flag_load = 0;

    // unmapped and absent channels
    op(0, 11'h207, '0);
    chk("lit_indv2_dead", rdata, 16'hDEAD);
    op(1, 11'h207, 16'h1111);
    op(0, 11'h208, '0);
    chk("lit_inda2_dead", rdata, 16'hDEAD);
    op(0, 11'h7FF, '0);
    chk("lit_unmapped", rdata, 16'hDEAD);

    // peripheral read acked in the third wait cycle
    pop(0, 11'h305, '0, 3, 16'h0BEE, nb);
    chk("lit_peri_rdata", rdata, 16'h0BEE);
    chk("lit_peri_busy_cycles", 16'(nb), 16'd3);
    chk("lit_peri_addr", 16'(last_paddr), 16'h0005);

    // timeout with interrupts enabled
    op(1, 11'h20B, 16'h0002);
    pop(0, 11'h310, '0, 0, '0, nb);
    chk("lit_to_rdata", rdata, 16'hDEAD);
    chk("lit_to_cycles", 16'(nb), 16'd15);
    chk("lit_to_irq", 16'(interrupt), 16'h1);
    op(0, 11'h20B, '0);
    chk("lit_irq_reg", rdata, 16'h0006);
    op(1, 11'h20B, 16'h0004);
    idle(1);
    chk("lit_irq_clr", 16'(interrupt), 16'h0);
    pop(1, 11'h3FF, 16'hBEEF, 1, '0, nb);
    chk("lit_pw_cycles", 16'(nb), 16'd1);
    rnd_fl = 1;

    reset_in_wait();
    idle(3);
    op(0, 11'h20B, '0);
    chk("lit_rst_buserr", 16'(rdata[2:1]), 16'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) begin
        case ($urandom_range(0, 3))
          0: a = 11'($urandom_range(0, 15));
          1: a = 11'h1FF;
          2: a = 11'h1FE;
          default: a = 11'($urandom_range(0, 511));
        endcase
        op(1'($urandom), a, 16'($urandom));
      end else if (r < 70) begin
        op(1'($urandom), 11'('h200 + $urandom_range(0, 11)), 16'($urandom));
      end else if (r < 80) begin
        a = ($urandom_range(0, 1) == 0) ? 11'($urandom_range('h20C, 'h2FF))
                                         : 11'($urandom_range('h400, 'h7FF));
        op(1'($urandom), a, 16'($urandom));
      end else if (r < 95) begin
        pop(1'($urandom), 11'('h300 + $urandom_range(0, 255)), 16'($urandom),
            int'($urandom_range(1, 16)), 16'($urandom), nb);
      end else begin
        idle(int'($urandom_range(1, 3)));
      end
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
